// File: rtl/wave_pkg.sv
// Shared types and elaboration helpers for the wave_gen sample generator.
package wave_pkg;

  typedef enum logic [1:0] {
    SAW      = 2'd0,
    SQUARE   = 2'd1,
    TRIANGLE = 2'd2,
    RSVD     = 2'd3
  } wave_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_MUL    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4,
    ST_FINISH = 3'd5
  } wave_state_t;

  // Phase-to-amplitude scale: floor(2^(out_w-1+frac) / half).
  function automatic logic [63:0] calc_k(input int unsigned out_w,
                                         input int unsigned frac,
                                         input int unsigned half);
    return (64'd1 << (out_w - 1 + frac)) / 64'(half);
  endfunction

endpackage

// File: rtl/wave_gen_phase_fold.sv
// Folds a phase into the multiplier operand, flags the upper half-cycle and bad requests.
// The TRIANGLE fold exists only when WAVE_GEN_TRIANGLE_EN is defined.
module phase_fold
  import wave_pkg::*;
#(
  parameter int unsigned PERIOD = 48000
) (
  input  logic [15:0] x_i,
  input  wave_mode_t  mode_i,
  output logic [15:0] u_c,
  output logic        upper_c,
  output logic        bad_c,
  output logic        mul_c
);

  localparam logic [16:0] PER  = 17'(PERIOD);
  localparam logic [16:0] HALF = 17'(PERIOD / 2);

  logic [16:0] xe;
  assign xe = {1'b0, x_i};

  always_comb begin
    upper_c = (xe >= HALF);
    bad_c   = 1'b0;
    mul_c   = 1'b0;
    u_c     = '0;
    case (mode_i)
      SAW: begin
        mul_c = 1'b1;
        u_c   = upper_c ? 16'(xe - HALF) : x_i;
      end
      SQUARE: begin
        mul_c = 1'b0;
      end
`ifdef WAVE_GEN_TRIANGLE_EN
      TRIANGLE: begin
        mul_c = 1'b1;
        u_c   = upper_c ? 16'(PER - xe) : x_i;
      end
`endif
      default: bad_c = 1'b1;
    endcase
    // Out-of-range phase is rejected outright rather than wrapped.
    if (xe >= PER) begin
      bad_c = 1'b1;
      mul_c = 1'b0;
      u_c   = '0;
    end
  end

endmodule

// File: rtl/wave_gen.sv
// Saw/square/triangle sample generator sharing an external multiplier.
// Define WAVE_GEN_TRIANGLE_EN to enable TRIANGLE; otherwise it reports err like RSVD.
module wave_gen
  import wave_pkg::*;
#(
  parameter int unsigned OUT_W    = 24,
  parameter int unsigned PERIOD   = 48000,
  parameter int unsigned FRAC     = 9,
  parameter int unsigned MULT_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [15:0]             x,
  output logic                    busy,
  output logic                    finish,
  output logic                    err,
  output logic signed [OUT_W-1:0] y,
  output logic [31:0]             mult_a,
  output logic [31:0]             mult_b,
  input  logic [63:0]             mult_p
);

  localparam int unsigned       HALF    = PERIOD / 2;
  localparam logic [31:0]       K       = 32'(calc_k(OUT_W, FRAC, HALF));
  localparam int unsigned       CNT_W   = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam logic [OUT_W-1:0]  MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]  MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};

  wave_state_t      state_q, state_d;
  wave_mode_t       mode_q, mode_d;
  logic [15:0]      x_q, x_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] r_q, r_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             finish_q, finish_d;
  logic [31:0]      mult_a_q, mult_a_d;
  logic [31:0]      mult_b_q, mult_b_d;

  logic [15:0]      fold_u;
  logic             fold_upper, fold_bad, fold_mul;
  logic [OUT_W-1:0] result;
  logic             unused_p;

  // Only the truncated window of the product is kept.
  assign unused_p = ^mult_p;

  phase_fold #(
    .PERIOD (PERIOD)
  ) u_fold (
    .x_i     (x_q),
    .mode_i  (mode_q),
    .u_c     (fold_u),
    .upper_c (fold_upper),
    .bad_c   (fold_bad),
    .mul_c   (fold_mul)
  );

  // Final sample from the held product window and the fold flags.
  always_comb begin
    result = '0;
    case (mode_q)
      SAW:      result = fold_upper ? (r_q - MIN_NEG) : r_q;
      SQUARE:   result = fold_upper ? MIN_NEG : MAX_POS;
`ifdef WAVE_GEN_TRIANGLE_EN
      TRIANGLE: result = {r_q[OUT_W-2:0], 1'b0} - MIN_NEG;
`endif
      default:  result = '0;
    endcase
    if (fold_bad) result = '0;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    y_d     = y_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = wave_mode_t'(mode);
          x_d     = x;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_MUL;
      ST_MUL: begin
        cnt_d   = CNT_W'(MULT_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Product is captured as WAIT exits so it stays stable through DONE.
        if (cnt_q == '0) begin
          r_d     = mult_p[FRAC +: OUT_W];
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        y_d     = result;
        err_d   = fold_bad;
        state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    busy_d   = (state_d != ST_IDLE);
    finish_d = (state_d == ST_FINISH);
    mult_a_d = (state_d == ST_MUL && fold_mul) ? 32'(fold_u) : '0;
    mult_b_d = (state_d == ST_MUL && fold_mul) ? K : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= SAW;
      x_q      <= '0;
      cnt_q    <= '0;
      r_q      <= '0;
      y_q      <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      mult_a_q <= '0;
      mult_b_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      x_q      <= x_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      y_q      <= y_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
      mult_a_q <= mult_a_d;
      mult_b_q <= mult_b_d;
    end
  end

  assign busy   = busy_q;
  assign finish = finish_q;
  assign err    = err_q;
  assign y      = y_q;
  assign mult_a = mult_a_q;
  assign mult_b = mult_b_q;

endmodule

// File: tb/tb_wave_gen.sv
// Directed-vector bench for wave_gen with a pipelined multiplier model.
module tb_wave_gen;
  import wave_pkg::*;

  localparam int unsigned MULT_LAT = 2;
  localparam int          LAT_CYC  = MULT_LAT + 4;
  localparam longint      KV       = 178956;

  logic               clk = 1'b0;
  logic               rst, start;
  logic [1:0]         mode;
  logic [15:0]        x;
  logic               busy, finish, err;
  logic signed [23:0] y;
  logic [31:0]        mult_a, mult_b;
  logic [63:0]        mult_p;
  logic [63:0]        pipe [MULT_LAT];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  m;
    logic [15:0] xv;
    longint      ey;
    logic        ee;
    longint      ea;
    longint      eb;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  wave_gen dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .x      (x),
    .busy   (busy),
    .finish (finish),
    .err    (err),
    .y      (y),
    .mult_a (mult_a),
    .mult_b (mult_b),
    .mult_p (mult_p)
  );

  always @(posedge clk) begin
    pipe[0] <= 64'(mult_a) * 64'(mult_b);
    for (int i = 1; i < MULT_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mult_p = pipe[MULT_LAT-1];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Start in cycle 0, observe cycles 1..12; optionally re-pulse start in cycles 2..5.
  task automatic do_req(input logic [1:0] m, input logic [15:0] xv, input longint ey,
                        input logic ee, input longint ea, input longint eb,
                        input bit spam, input bit nowait, input string tag);
    int fcyc, fcount, busy_cnt, stray;
    longint ga, gb, gy, gerr;
    fcyc = -1; fcount = 0; busy_cnt = 0; stray = 0;
    ga = 0; gb = 0; gy = 0; gerr = 0;
    if (!nowait) @(negedge clk);
    start = 1'b1; mode = m; x = xv;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = spam && (c >= 2) && (c <= 5);
      if (busy) busy_cnt++;
      if (finish) begin
        fcount++;
        if (fcyc < 0) begin
          fcyc = c;
          gy   = longint'(y);
          gerr = longint'(err);
        end
      end
      if (c == 2) begin
        ga = longint'(mult_a);
        gb = longint'(mult_b);
      end else if (mult_a != 0 || mult_b != 0) begin
        stray++;
      end
    end
    start = 1'b0;
    chk($sformatf("%s finish_cycle", tag), fcyc, LAT_CYC);
    chk($sformatf("%s finish_count", tag), fcount, 1);
    chk($sformatf("%s busy_cycles", tag), busy_cnt, LAT_CYC);
    chk($sformatf("%s y", tag), gy, ey);
    chk($sformatf("%s err", tag), gerr, longint'(ee));
    chk($sformatf("%s mult_a", tag), ga, ea);
    chk($sformatf("%s mult_b", tag), gb, eb);
    chk($sformatf("%s stray_operands", tag), stray, 0);
    chk($sformatf("%s y_held", tag), longint'(y), ey);
  endtask

  initial begin
    int ab_fin;
    for (int i = 0; i < MULT_LAT; i++) pipe[i] = '0;
    rst = 1'b1; start = 1'b0; mode = 2'd0; x = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst busy", longint'(busy), 0);
    chk("rst finish", longint'(finish), 0);
    chk("rst err", longint'(err), 0);
    chk("rst y", longint'(y), 0);
    chk("rst mult_a", longint'(mult_a), 0);
    chk("rst mult_b", longint'(mult_b), 0);
    rst = 1'b0;

    tbl.push_back(vec_t'{2'd0, 16'd12000, 4194281,  1'b0, 12000, KV});
    tbl.push_back(vec_t'{2'd0, 16'd24000, -8388608, 1'b0, 0,     KV});
    tbl.push_back(vec_t'{2'd0, 16'd0,     0,        1'b0, 0,     KV});
    tbl.push_back(vec_t'{2'd0, 16'd36000, -4194327, 1'b0, 12000, KV});
    tbl.push_back(vec_t'{2'd0, 16'd47999, -396,     1'b0, 23999, KV});
    tbl.push_back(vec_t'{2'd1, 16'd100,   8388607,  1'b0, 0,     0});
    tbl.push_back(vec_t'{2'd1, 16'd30000, -8388608, 1'b0, 0,     0});
    tbl.push_back(vec_t'{2'd1, 16'd23999, 8388607,  1'b0, 0,     0});
    tbl.push_back(vec_t'{2'd1, 16'd24000, -8388608, 1'b0, 0,     0});
    tbl.push_back(vec_t'{2'd3, 16'd100,   0,        1'b1, 0,     0});
    tbl.push_back(vec_t'{2'd0, 16'd48000, 0,        1'b1, 0,     0});
    tbl.push_back(vec_t'{2'd1, 16'd65535, 0,        1'b1, 0,     0});
`ifdef WAVE_GEN_TRIANGLE_EN
    tbl.push_back(vec_t'{2'd2, 16'd0,     -8388608, 1'b0, 0,     KV});
    tbl.push_back(vec_t'{2'd2, 16'd12000, -46,      1'b0, 12000, KV});
    tbl.push_back(vec_t'{2'd2, 16'd24000, 8388516,  1'b0, 24000, KV});
    tbl.push_back(vec_t'{2'd2, 16'd36000, -46,      1'b0, 12000, KV});
    tbl.push_back(vec_t'{2'd2, 16'd48000, 0,        1'b1, 0,     0});
`else
    tbl.push_back(vec_t'{2'd2, 16'd0,     0,        1'b1, 0,     0});
    tbl.push_back(vec_t'{2'd2, 16'd12000, 0,        1'b1, 0,     0});
    tbl.push_back(vec_t'{2'd2, 16'd24000, 0,        1'b1, 0,     0});
`endif

    foreach (tbl[i])
      do_req(tbl[i].m, tbl[i].xv, tbl[i].ey, tbl[i].ee, tbl[i].ea, tbl[i].eb,
             1'b0, 1'b0, $sformatf("v%0d", i));

    // Repeated start while busy must not queue a second request.
    do_req(2'd0, 16'd48000, 0, 1'b1, 0, 0, 1'b1, 1'b0, "spam");

    // Leave a nonzero sample behind, then abort a request in WAIT.
    do_req(2'd1, 16'd100, 8388607, 1'b0, 0, 0, 1'b0, 1'b0, "pre_rst");
    ab_fin = 0;
    @(negedge clk);
    start = 1'b1; mode = 2'd0; x = 16'd36000;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (finish) ab_fin++;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort finish_seen", ab_fin, 0);
    chk("abort busy", longint'(busy), 0);
    chk("abort finish", longint'(finish), 0);
    chk("abort y", longint'(y), 0);
    chk("abort err", longint'(err), 0);
    chk("abort mult_a", longint'(mult_a), 0);
    chk("abort mult_b", longint'(mult_b), 0);
    rst = 1'b0;
    do_req(2'd0, 16'd12000, 4194281, 1'b0, 12000, KV, 1'b0, 1'b1, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_gen.md
WAVE_GEN -- requirements
Module: wave_gen

Interface
REQ-001 SHALL have parameter OUT_W, default 24, output sample width, signed.
REQ-002 SHALL have parameter PERIOD, default 48000, phase count for one cycle (0..2*pi); PERIOD even, <= 2^16.
REQ-003 SHALL have parameter FRAC, default 9, right-shift applied to multiplier product.
REQ-004 SHALL have parameter MULT_LAT, default 2, shared-multiplier latency in cycles (>= 1).
REQ-005 SHALL have port clk  in  1  clock; all logic on posedge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  in  1  request; sampled only in IDLE.
REQ-008 SHALL have port mode  in  2  waveform select (wave_pkg::wave_mode_t), latched with start.
REQ-009 SHALL have port x  in  16  phase, valid range [0, PERIOD), latched with start.
REQ-010 SHALL have port busy  out  1  high in every state except IDLE.
REQ-011 SHALL have port finish  out  1  one-cycle pulse; y and err valid during it and held until next finish.
REQ-012 SHALL have port err  out  1  x was >= PERIOD for this request.
REQ-013 SHALL have port y  out  OUT_W  signed sample.
REQ-014 SHALL have ports mult_a, mult_b  out  32  operands to shared multiplier; mult_p  in  64  product.

Function
REQ-015 SHALL use states IDLE -> LOAD -> MUL -> WAIT -> DONE -> FINISH -> IDLE.
REQ-016 SHALL accept start only in IDLE; start while busy ignored, no queueing.
REQ-017 SHALL assert finish exactly MULT_LAT+4 cycles after the accepting edge (6 at default), for every mode including err.
REQ-018 SHALL define HALF=PERIOD/2, K=floor(2^(OUT_W-1+FRAC)/HALF), elaboration-time constant; K < 2^32.
REQ-019 SHALL drive mult_a=operand u (zero-extended), mult_b=K only in MUL; both 0 in all other states.
REQ-020 SHALL count MULT_LAT-1 cycles in WAIT (down-counter), then sample P=mult_p in DONE; R=P[FRAC+OUT_W-1:FRAC] (truncate).
REQ-021 SAW: u = x mod HALF; y = R, minus 2^(OUT_W-1) when x >= HALF (wraps modulo 2^OUT_W).
REQ-022 SQUARE: y = 2^(OUT_W-1)-1 when x < HALF, else -2^(OUT_W-1); multiplier driven 0, latency unchanged.
REQ-023 TRIANGLE: u = x when x < HALF, else PERIOD-x; y = 2*R - 2^(OUT_W-1), modulo 2^OUT_W.
REQ-024 mode value 3 (reserved) SHALL produce y=0, err=1.
REQ-025 x >= PERIOD SHALL produce y=0, err=1; no wrap.
REQ-026 y and err SHALL change only on the DONE->FINISH edge.

Reset
REQ-027 rst SHALL force state IDLE, y=0, err=0, finish=0, busy=0, mult_a=mult_b=0, counter=0, next cycle.
REQ-028 rst mid-operation SHALL abort with no finish pulse; start sampled again from the first non-reset cycle.

Configuration
REQ-029 Macro WAVE_GEN_TRIANGLE_EN: defined -> TRIANGLE per REQ-023; undefined -> TRIANGLE treated as reserved per REQ-024, fold logic absent.

Structure
REQ-030 Package wave_pkg SHALL hold wave_mode_t (SAW=0, SQUARE=1, TRIANGLE=2, RSVD=3) and state enum type.
REQ-031 Sub-module phase_fold (combinational: x, mode -> u, upper-half flag, range error) SHALL be instantiated once.

Verification
REQ-032 defaults, SAW, x=12000 -> finish 6 cycles after start, y=4194281, err=0.
REQ-033 SAW x=24000 -> y=-8388608; SAW x=0 -> y=0; mult_a=24000-24000=0 in MUL.
REQ-034 SQUARE x=100 -> y=8388607; x=30000 -> y=-8388608; mult_a=mult_b=0 throughout.
REQ-035 TRIANGLE x=0 -> -8388608; x=12000 -> -46; x=24000 -> 8388516 (macro on); macro off -> y=0, err=1.
REQ-036 x=48000 -> y=0, err=1, finish still at cycle 6; start pulsed at cycles 2..5 -> ignored, one finish.
REQ-037 rst asserted in WAIT -> no finish, outputs 0; new start next cycle completes normally.
